cozy_lsu: RTL and testbench

- Load/store unit sitting directly upstream of the 16-bit byte-addressed block RAM (cozy_memory).
- Accepts CPU load/store requests on a valid/ready handshake and drives the RAM's addr/din/bwe.
- Absorbs the RAM's 1-cycle read latency, extracts and extends bytes, and returns one response per request.
- Memory is little-endian: the even byte is [7:0] and the odd byte is [15:8] of a word.

---
 rtl/cozy_lsu_pkg.sv | 24 ++
 rtl/cozy_lsu_extend.sv | 10 +
 rtl/cozy_lsu.sv | 170 +++++++++++++++++
 tb/tb_cozy_lsu.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cozy_lsu_pkg.sv
// Shared definitions for the cozy load/store unit: RAM byte-write-enable codes,
// FSM state encodings and the latched request record.
package cozy_lsu_pkg;

  localparam logic [1:0] BWE_NONE = 2'b00;
  localparam logic [1:0] BWE_BYTE = 2'b01;
  localparam logic [1:0] BWE_WORD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ACC1 = 3'd1,
    ST_ACC2 = 3'd2,
    ST_RD1  = 3'd3,
    ST_RD2  = 3'd4
  } lsu_state_e;

  typedef struct packed {
    logic        write;
    logic        is_byte;
    logic        sgn;
    logic [15:0] wdata;
  } lsu_req_t;

endpackage

// File: rtl/cozy_lsu_extend.sv
// Byte-to-halfword extension for byte loads (zero or sign fill of bits [15:8]).
module cozy_lsu_extend (
  input  logic [7:0]  byte_in,
  input  logic        sign_en,
  output logic [15:0] data_out
);

  assign data_out = {{8{sign_en & byte_in[7]}}, byte_in};

endmodule

// File: rtl/cozy_lsu.sv
// Load/store unit in front of the 16-bit byte-addressed cozy_memory block RAM.
// Build option COZY_LSU_MISALIGN_EN splits misaligned words into two byte accesses.
module cozy_lsu
  import cozy_lsu_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic          req_byte,
  input  logic          req_signed,
  input  logic [AW-1:0] req_addr,
  input  logic [15:0]   req_wdata,
  output logic          resp_valid,
  output logic [15:0]   resp_rdata,
  output logic          resp_err,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_din,
  output logic [1:0]    mem_bwe,
  input  logic [15:0]   mem_dout
);

  lsu_state_e    state_q, state_d;
  lsu_req_t      req_q, req_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          resp_valid_q, resp_valid_d;
  logic [15:0]   resp_rdata_q, resp_rdata_d;
  logic          resp_err_q, resp_err_d;
  logic [15:0]   ext_data;
`ifdef COZY_LSU_MISALIGN_EN
  logic [7:0]    lo_q, lo_d;
  logic          split_q;

  assign split_q = !req_q.is_byte && addr_q[0];
`endif

  cozy_lsu_extend u_extend (
    .byte_in  (mem_dout[7:0]),
    .sign_en  (req_q.sgn),
    .data_out (ext_data)
  );

  // NOTE: every always_comb output gets a default first so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    addr_d       = addr_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    resp_err_d   = 1'b0;
`ifdef COZY_LSU_MISALIGN_EN
    lo_d         = lo_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          req_d  = '{write: req_write, is_byte: req_byte, sgn: req_signed, wdata: req_wdata};
          addr_d = req_addr;
`ifdef COZY_LSU_MISALIGN_EN
          state_d = ST_ACC1;
`else
          // Misaligned word is rejected on the accept edge without touching the RAM.
          if (!req_byte && req_addr[0]) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d = ST_ACC1;
          end
`endif
        end
      end
      ST_ACC1: begin
`ifdef COZY_LSU_MISALIGN_EN
        if (split_q) begin
          state_d = ST_ACC2;
        end else
`endif
        if (req_q.write) begin
          resp_valid_d = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_RD1;
        end
      end
`ifdef COZY_LSU_MISALIGN_EN
      ST_ACC2: begin
        lo_d = mem_dout[7:0];
        if (req_q.write) begin
          resp_valid_d = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_RD2;
        end
      end
      ST_RD2: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = {mem_dout[7:0], lo_q};
        state_d      = ST_IDLE;
      end
`endif
      ST_RD1: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = req_q.is_byte ? ext_data : mem_dout;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      req_q        <= '0;
      addr_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
`ifdef COZY_LSU_MISALIGN_EN
      lo_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
`ifdef COZY_LSU_MISALIGN_EN
      lo_q         <= lo_d;
`endif
    end
  end

  // RAM controls decode from registered state only, so reset kills a write at once.
  always_comb begin
    mem_addr = addr_q;
    mem_bwe  = BWE_NONE;
    mem_din  = '0;
`ifdef COZY_LSU_MISALIGN_EN
    if (state_q == ST_ACC2) begin
      mem_addr = addr_q + AW'(1);
      if (req_q.write) begin
        mem_bwe = BWE_BYTE;
        mem_din = {8'h00, req_q.wdata[15:8]};
      end
    end
`endif
    if (state_q == ST_ACC1 && req_q.write) begin
      if (req_q.is_byte || addr_q[0]) begin
        mem_bwe = BWE_BYTE;
        mem_din = {8'h00, req_q.wdata[7:0]};
      end else begin
        mem_bwe = BWE_WORD;
        mem_din = req_q.wdata;
      end
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_cozy_lsu.sv
// Directed self-checking bench for cozy_lsu with a behavioural byte-addressed RAM;
// expectations follow COZY_LSU_MISALIGN_EN when it is defined for the build.
module tb_cozy_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write, req_byte, req_signed;
  logic [15:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [15:0] resp_rdata;
  logic [15:0] mem_addr, mem_din, mem_dout;
  logic [1:0]  mem_bwe;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram [0:65535];

  cozy_lsu #(.AW(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_byte   (req_byte),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_bwe    (mem_bwe),
    .mem_dout   (mem_dout)
  );

  always #5 clk = ~clk;

  // RAM model: 1-cycle read latency, byte at the addressed location lands in [7:0].
  always @(posedge clk) begin
    logic [15:0] a1;
    a1 = mem_addr + 16'd1;
    mem_dout <= {ram[a1], ram[mem_addr]};
    if (mem_bwe[0]) ram[mem_addr] <= mem_din[7:0];
    if (mem_bwe == 2'b11) ram[a1] <= mem_din[15:8];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Per-transaction observations.
  int          lat, nw;
  logic [15:0] rd, wa0, wa1, wd0, wd1;
  logic [1:0]  wb0, wb1;
  logic        er;

  // Issue one request, follow it to its response (bounded), then confirm the pulse drops.
  task automatic issue(input logic w, input logic b, input logic s,
                       input logic [15:0] a, input logic [15:0] d);
    bit got;
    req_write = w; req_byte = b; req_signed = s; req_addr = a; req_wdata = d;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0; nw = 0; got = 0; rd = '0; er = 1'b0;
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; wb0 = '0; wb1 = '0;
    for (int c = 1; c <= 8 && !got; c++) begin
      if (mem_bwe != 2'b00) begin
        if (nw == 0) begin wa0 = mem_addr; wb0 = mem_bwe; wd0 = mem_din; end
        else if (nw == 1) begin wa1 = mem_addr; wb1 = mem_bwe; wd1 = mem_din; end
        nw++;
      end
      if (resp_valid) begin
        got = 1; lat = c; rd = resp_rdata; er = resp_err;
      end else begin
        @(posedge clk); #1;
      end
    end
    if (got) begin
      @(posedge clk); #1;
      check("resp_pulse_one_cycle", resp_valid, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", req_ready, 1'b1);
    check("rst_bwe", mem_bwe, 2'b00);
    check("rst_addr", mem_addr, 16'h0000);
    check("rst_din", mem_din, 16'h0000);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_rdata", resp_rdata, 16'h0000);
    check("rst_err", resp_err, 1'b0);

    // Aligned word store then load.
    issue(1'b1, 1'b0, 1'b0, 16'h0010, 16'h1234);
    check("sw_lat", lat, 2);
    check("sw_nwrites", nw, 1);
    check("sw_bwe", wb0, 2'b11);
    check("sw_addr", wa0, 16'h0010);
    check("sw_din", wd0, 16'h1234);
    check("sw_rdata", rd, 16'h0000);
    check("sw_err", er, 1'b0);
    issue(1'b0, 1'b0, 1'b0, 16'h0010, 16'hFFFF);
    check("lw_lat", lat, 3);
    check("lw_nwrites", nw, 0);
    check("lw_rdata", rd, 16'h1234);

    // Byte store to the odd lane, then signed/unsigned/word reads.
    issue(1'b1, 1'b1, 1'b0, 16'h0011, 16'h7780);
    check("sb_lat", lat, 2);
    check("sb_bwe", wb0, 2'b01);
    check("sb_addr", wa0, 16'h0011);
    check("sb_din_lo", wd0[7:0], 8'h80);
    issue(1'b0, 1'b1, 1'b1, 16'h0011, 16'h0000);
    check("lb_signed", rd, 16'hFF80);
    check("lb_signed_lat", lat, 3);
    issue(1'b0, 1'b1, 1'b0, 16'h0011, 16'h0000);
    check("lb_unsigned", rd, 16'h0080);
    issue(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000);
    check("lw_after_sb", rd, 16'h8034);

    // Misaligned word store/load at 0x0021.
    issue(1'b1, 1'b0, 1'b0, 16'h0021, 16'hBEEF);
`ifdef COZY_LSU_MISALIGN_EN
    check("msw_lat", lat, 3);
    check("msw_nwrites", nw, 2);
    check("msw_addr0", wa0, 16'h0021);
    check("msw_addr1", wa1, 16'h0022);
    check("msw_bwe0", wb0, 2'b01);
    check("msw_bwe1", wb1, 2'b01);
    check("msw_din0", wd0[7:0], 8'hEF);
    check("msw_din1", wd1[7:0], 8'hBE);
    check("msw_err", er, 1'b0);
    issue(1'b0, 1'b0, 1'b0, 16'h0021, 16'h0000);
    check("mlw_lat", lat, 4);
    check("mlw_rdata", rd, 16'hBEEF);
`else
    check("msw_lat", lat, 1);
    check("msw_err", er, 1'b1);
    check("msw_nwrites", nw, 0);
    check("msw_rdata", rd, 16'h0000);
    issue(1'b0, 1'b0, 1'b0, 16'h0021, 16'h0000);
    check("mlw_lat", lat, 1);
    check("mlw_err", er, 1'b1);
    check("mlw_rdata", rd, 16'h0000);
    issue(1'b0, 1'b1, 1'b0, 16'h0021, 16'h0000);
    check("msw_nowrite_lo", rd, 16'h0000);
    check("lb_aligned_err", er, 1'b0);
    issue(1'b0, 1'b1, 1'b0, 16'h0022, 16'h0000);
    check("msw_nowrite_hi", rd, 16'h0000);
`endif

    // Misaligned word at the top of memory wraps to 0x0000.
    issue(1'b1, 1'b0, 1'b0, 16'hFFFF, 16'hA55A);
`ifdef COZY_LSU_MISALIGN_EN
    check("wrap_nwrites", nw, 2);
    check("wrap_addr0", wa0, 16'hFFFF);
    check("wrap_addr1", wa1, 16'h0000);
    issue(1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0000);
    check("wrap_lb_ffff", rd, 16'h005A);
    issue(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
    check("wrap_lb_0000", rd, 16'h00A5);
`else
    check("wrap_err", er, 1'b1);
    check("wrap_nwrites", nw, 0);
    issue(1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0000);
    check("wrap_lb_ffff", rd, 16'h0000);
    issue(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
    check("wrap_lb_0000", rd, 16'h0000);
`endif

    // Reset during ACC1 of a word store aborts it without a clock edge.
    req_write = 1'b1; req_byte = 1'b0; req_signed = 1'b0;
    req_addr = 16'h0040; req_wdata = 16'h5555; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("abort_bwe_before", mem_bwe, 2'b11);
    rst_n = 1'b0;
    #1;
    check("abort_bwe_async", mem_bwe, 2'b00);
    check("abort_din_async", mem_din, 16'h0000);
    begin
      int pulses = 0;
      for (int c = 0; c < 4; c++) begin
        @(posedge clk); #1;
        if (c == 1) rst_n = 1'b1;
        if (resp_valid) pulses++;
      end
      check("abort_no_resp", pulses, 0);
    end
    issue(1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000);
    check("abort_target_unchanged", rd, 16'h0000);

    // Back-to-back loads with req_valid held high.
    req_write = 1'b0; req_byte = 1'b0; req_signed = 1'b0;
    req_addr = 16'h0010; req_valid = 1'b1;
    @(posedge clk); #1;
    req_byte = 1'b1; req_signed = 1'b1; req_addr = 16'h0011;
    check("b2b_busy", req_ready, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("b2b_resp1_valid", resp_valid, 1'b1);
    check("b2b_resp1_rdata", resp_rdata, 16'h8034);
    check("b2b_ready_in_resp", req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("b2b_second_accepted", req_ready, 1'b0);
    check("b2b_gap", resp_valid, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("b2b_resp2_valid", resp_valid, 1'b1);
    check("b2b_resp2_rdata", resp_rdata, 16'hFF80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
